// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Monitors a multiplexed 8-digit active-low 7-segment scan,
//               waits for each dwell to settle, and rebuilds the hex value.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [7:0]  an,
    input  logic [6:0]  seg,
    output logic [31:0] value,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        bad_pattern,
    output logic        multi_err
);

    localparam logic [1:0] c_st_wait    = 2'd0;
    localparam logic [1:0] c_st_capture = 2'd1;
    localparam logic [1:0] c_st_hold    = 2'd2;

    localparam logic [7:0] c_settle_max = 8'(SETTLE_CYCLES);
    localparam logic [7:0] c_settle_m1  = 8'(SETTLE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [14:0] r_sample;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic        w_same;
    logic        w_settled;

    logic [31:0] r_value;
    logic [7:0]  r_digit_valid;
    logic [7:0]  r_seen;
    logic        r_frame_done;
    logic        r_bad_pattern;
    logic        r_multi_err;

    logic [7:0]  w_cap_low;
    logic [6:0]  w_cap_seg;
    logic        w_one_hot;
    logic [2:0]  w_idx;
    logic [7:0]  w_idx_mask;
    logic [7:0]  w_seen_set;
    logic [3:0]  w_nibble;
    logic        w_legal;
    logic        w_do_write;
    logic [7:0]  w_in_low;
    logic        w_in_multi;

    // ------------------------------------------------------------------
    // Sample register and stability counter
    // ------------------------------------------------------------------
    assign w_same    = ({an, seg} == r_sample);
    assign w_settled = (w_cnt_next == c_settle_m1);

    always_comb begin
        w_cnt_next = 8'd0;
        if (w_same) begin
            if (r_cnt >= c_settle_max) begin
                w_cnt_next = r_cnt;
            end else begin
                w_cnt_next = r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sample <= '1;
            r_cnt    <= 8'd0;
            r_state  <= c_st_wait;
        end else begin
            r_sample <= {an, seg};
            r_cnt    <= w_cnt_next;
            r_state  <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Dwell FSM. A sample change seen while leaving CAPTURE starts the next
    // dwell immediately, so a dwell of exactly SETTLE_CYCLES is not lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_wait: begin
                if (w_settled) begin
                    w_state_next = c_st_capture;
                end
            end
            c_st_capture: begin
                if (w_same) begin
                    w_state_next = c_st_hold;
                end else begin
                    w_state_next = w_settled ? c_st_capture : c_st_wait;
                end
            end
            c_st_hold: begin
                if (!w_same) begin
                    w_state_next = w_settled ? c_st_capture : c_st_wait;
                end
            end
            default: begin
                w_state_next = c_st_wait;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Anode qualification of the captured sample
    // ------------------------------------------------------------------
    assign w_cap_low = ~r_sample[14:7];
    assign w_cap_seg = r_sample[6:0];
    assign w_one_hot = (w_cap_low != 8'd0) && ((w_cap_low & (w_cap_low - 8'd1)) == 8'd0);

    always_comb begin
        w_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (w_cap_low[k]) begin
                w_idx = k[2:0];
            end
        end
    end

    assign w_idx_mask = 8'd1 << w_idx;
    assign w_seen_set = r_seen | w_idx_mask;
    assign w_do_write = (r_state == c_st_capture) && w_one_hot;

    assign w_in_low   = ~an;
    assign w_in_multi = ((w_in_low & (w_in_low - 8'd1)) != 8'd0);

    // ------------------------------------------------------------------
    // Segment pattern to nibble
    // ------------------------------------------------------------------
    always_comb begin
        w_nibble = 4'h0;
        w_legal  = 1'b1;
        case (w_cap_seg)
            7'b1000000: w_nibble = 4'h0;
            7'b1111001: w_nibble = 4'h1;
            7'b0100100: w_nibble = 4'h2;
            7'b0110000: w_nibble = 4'h3;
            7'b0011001: w_nibble = 4'h4;
            7'b0010010: w_nibble = 4'h5;
            7'b0000010: w_nibble = 4'h6;
            7'b1111000: w_nibble = 4'h7;
            7'b0000000: w_nibble = 4'h8;
            7'b0010000: w_nibble = 4'h9;
            7'b0001000: w_nibble = 4'hA;
            7'b0000011: w_nibble = 4'hB;
            7'b1000110: w_nibble = 4'hC;
            7'b0100001: w_nibble = 4'hD;
            7'b0000110: w_nibble = 4'hE;
            7'b0001110: w_nibble = 4'hF;
            default:    w_legal  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_value       <= 32'd0;
            r_digit_valid <= 8'd0;
            r_seen        <= 8'd0;
            r_frame_done  <= 1'b0;
            r_bad_pattern <= 1'b0;
            r_multi_err   <= 1'b0;
        end else begin
            r_frame_done  <= 1'b0;
            r_bad_pattern <= 1'b0;
            if (w_in_multi) begin
                r_multi_err <= 1'b1;
            end
            if (w_do_write) begin
                if (w_legal) begin
                    r_value[{w_idx, 2'b00} +: 4] <= w_nibble;
                    r_digit_valid[w_idx]         <= 1'b1;
                end else begin
                    r_digit_valid[w_idx] <= 1'b0;
                    r_bad_pattern        <= 1'b1;
                end
                // The completing capture also opens the next frame.
                if (&w_seen_set) begin
                    r_frame_done <= 1'b1;
                    r_seen       <= w_idx_mask;
                end else begin
                    r_seen <= w_seen_set;
                end
            end
        end
    end

    assign value       = r_value;
    assign digit_valid = r_digit_valid;
    assign frame_done  = r_frame_done;
    assign bad_pattern = r_bad_pattern;
    assign multi_err   = r_multi_err;

endmodule
`default_nettype wire
